// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - icache/dcache/memory bus bundle for the line-fill arbiter
interface cache_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
);
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_resp;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic                  d_resp;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [LINE_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;
    logic                  mem_resp;
    logic [LINE_WIDTH-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata,
        input  mem_ready, mem_resp, mem_rdata,
        output i_resp, i_rdata, d_resp, d_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    // Cache and memory side
    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata,
        output mem_ready, mem_resp, mem_rdata,
        input  i_resp, i_rdata, d_resp, d_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - round-robin icache/dcache arbiter onto a single memory port
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic               clk,
    input  logic               rst,
    cache_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                state_q, state_d;
    logic                  grant_d_q, grant_d_d;     // 1: dcache owns the transaction
    logic                  op_wr_q, op_wr_d;
    logic                  last_d_q, last_d_d;       // 1: dcache was granted most recently
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic                  i_resp_q, i_resp_d;
    logic                  d_resp_q, d_resp_d;

    logic req_i, req_d, pick_d, pick_wr;

    // Simultaneous requests go to whichever side did not win last time.
    assign req_i   = bus.i_read;
    assign req_d   = bus.d_read | bus.d_write;
    assign pick_d  = req_d & (~req_i | ~last_d_q);
    assign pick_wr = pick_d & bus.d_write;          // read+write together counts as a write

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_resp    = i_resp_q;
    assign bus.d_resp    = d_resp_q;
    assign bus.i_rdata   = rdata_q;
    assign bus.d_rdata   = rdata_q;

    // Next-state and registered-output computation for the transaction FSM
    always_comb begin
        state_d     = state_q;
        grant_d_d   = grant_d_q;
        op_wr_d     = op_wr_q;
        last_d_d    = last_d_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        i_resp_d    = 1'b0;
        d_resp_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_i || req_d) begin
                    grant_d_d   = pick_d;
                    last_d_d    = pick_d;
                    op_wr_d     = pick_wr;
                    addr_d      = pick_d ? bus.d_addr : bus.i_addr;
                    wdata_d     = pick_wr ? bus.d_wdata : '0;
                    mem_read_d  = ~pick_wr;
                    mem_write_d = pick_wr;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.mem_ready) begin
                    state_d = S_WAIT;
                end else begin
                    mem_read_d  = mem_read_q;
                    mem_write_d = mem_write_q;
                end
            end
            S_WAIT: begin
                if (bus.mem_resp) begin
                    rdata_d  = bus.mem_rdata;
                    i_resp_d = ~grant_d_q;
                    d_resp_d = grant_d_q;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any in-flight transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_d_q   <= 1'b0;
            op_wr_q     <= 1'b0;
            last_d_q    <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            i_resp_q    <= 1'b0;
            d_resp_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_d_q   <= grant_d_d;
            op_wr_q     <= op_wr_d;
            last_d_q    <= last_d_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            i_resp_q    <= i_resp_d;
            d_resp_q    <= d_resp_d;
        end
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_mem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

    cache_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit model_last_d = 1'b1;   // who was served most recently (1 = dcache)

    typedef struct {
        bit            ir, dr, dw;
        logic [AW-1:0] ia, da;
        logic [LW-1:0] dwd;
        int            rdy, rsp;
        logic [LW-1:0] rd_i, rd_d;
        bit            exp_first_d;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // One full memory transaction seen from the memory side and the requester side
    task automatic serve(input bit exp_d, input bit exp_wr, input logic [AW-1:0] ea,
                         input logic [LW-1:0] ew, input int rdy, input int rsp,
                         input logic [LW-1:0] rd);
        int n = 0;
        logic [LW-1:0] exp_wd;
        exp_wd = exp_wr ? ew : '0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.mem_read || bus.mem_write) && n < 20);
        chk("cmd_seen", (n < 20), 1);
        if (n >= 20) return;
        chk("cmd_op", {bus.mem_read, bus.mem_write}, exp_wr ? 2'b01 : 2'b10);
        chk("cmd_addr", bus.mem_addr, ea);
        chk("cmd_wdata", bus.mem_wdata, exp_wd);
        for (int k = 0; k < rdy; k++) begin
            bus.mem_ready = 1'b0;
            if (exp_d) begin
                bus.d_addr  = $urandom;
                bus.d_wdata = rnd_line();
            end else begin
                bus.i_addr = $urandom;
            end
            @(negedge clk);
            chk("stall_op", {bus.mem_read, bus.mem_write}, exp_wr ? 2'b01 : 2'b10);
            chk("stall_addr", bus.mem_addr, ea);
            chk("stall_wdata", bus.mem_wdata, exp_wd);
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        chk("wait_cmd_off", {bus.mem_read, bus.mem_write}, 2'b00);
        for (int k = 0; k < rsp; k++) @(negedge clk);
        chk("no_early_resp", {bus.i_resp, bus.d_resp}, 2'b00);
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = rd;
        @(negedge clk);
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = rnd_line();
        chk("resp_who", {bus.i_resp, bus.d_resp}, exp_d ? 2'b01 : 2'b10);
        chk("i_rdata", bus.i_rdata, rd);
        chk("d_rdata", bus.d_rdata, rd);
        if (exp_d) begin
            bus.d_read  = 1'b0;
            bus.d_write = 1'b0;
        end else begin
            bus.i_read = 1'b0;
        end
        model_last_d = exp_d;
        @(negedge clk);
        chk("resp_one_cycle", {bus.i_resp, bus.d_resp}, 2'b00);
    endtask

    task automatic serve_side(input bit side_d, input vec_t tv, input logic [LW-1:0] rd);
        if (side_d) serve(1'b1, tv.dw, tv.da, tv.dwd, tv.rdy, tv.rsp, rd);
        else        serve(1'b0, 1'b0, tv.ia, '0, tv.rdy, tv.rsp, rd);
    endtask

    task automatic apply(input vec_t tv);
        bus.i_read  = tv.ir;
        bus.i_addr  = tv.ia;
        bus.d_read  = tv.dr;
        bus.d_write = tv.dw;
        bus.d_addr  = tv.da;
        bus.d_wdata = tv.dwd;
        serve_side(tv.exp_first_d, tv, tv.exp_first_d ? tv.rd_d : tv.rd_i);
        if (tv.ir && (tv.dr || tv.dw))
            serve_side(!tv.exp_first_d, tv, tv.exp_first_d ? tv.rd_i : tv.rd_d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv;
        bus.i_read = 0; bus.i_addr = '0; bus.d_read = 0; bus.d_write = 0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.mem_ready = 0; bus.mem_resp = 0;
        bus.mem_rdata = '0;

        //            ir dr dw  ia            da            dwd         rdy rsp rd_i        rd_d       first_d
        vecs[0] = '{1, 1, 0, 32'h0000_1000, 32'h0000_2000, '0,         0, 1, 256'h11,    256'h22,   1'b0};
        vecs[1] = '{1, 0, 0, 32'hAAAA_A000, 32'h0,         '0,         0, 3, 256'h1234,  256'h0,    1'b0};
        vecs[2] = '{1, 1, 0, 32'h0000_3000, 32'h0000_4000, '0,         1, 0, 256'h33,    256'h44,   1'b1};
        vecs[3] = '{0, 0, 1, 32'h0,         32'h0000_0100, {LW{1'b1}}, 5, 2, 256'h0,     256'h55,   1'b1};
        vecs[4] = '{0, 1, 1, 32'h0,         32'h0000_0200, 256'hBEEF,  2, 1, 256'h0,     256'h66,   1'b1};
        vecs[5] = '{1, 0, 1, 32'h0000_5000, 32'h0000_6000, 256'hCAFE,  1, 2, 256'h77,    256'h88,   1'b0};

        repeat (3) @(negedge clk);
        chk("rst_cmd", {bus.mem_read, bus.mem_write}, 2'b00);
        chk("rst_resp", {bus.i_resp, bus.d_resp}, 2'b00);
        chk("rst_addr", bus.mem_addr, '0);
        chk("rst_rdata", bus.i_rdata, '0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) apply(vecs[v]);

        // Spurious mem_resp in IDLE, then in ISSUE
        bus.mem_resp = 1'b1;
        @(negedge clk);
        bus.mem_resp = 1'b0;
        chk("spur_idle_resp", {bus.i_resp, bus.d_resp}, 2'b00);
        chk("spur_idle_cmd", {bus.mem_read, bus.mem_write}, 2'b00);
        bus.i_read = 1'b1;
        bus.i_addr = 32'h0000_7000;
        @(negedge clk);
        bus.mem_resp = 1'b1;
        @(negedge clk);
        bus.mem_resp = 1'b0;
        chk("spur_issue_resp", {bus.i_resp, bus.d_resp}, 2'b00);
        chk("spur_issue_cmd", {bus.mem_read, bus.mem_write}, 2'b10);
        serve(1'b0, 1'b0, 32'h0000_7000, '0, 0, 1, 256'h99);

        // Reset while waiting on memory, followed by a late mem_resp
        bus.i_read = 1'b1;
        bus.i_addr = 32'h0000_0040;
        @(negedge clk);
        chk("rw_cmd", bus.mem_read, 1'b1);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rw_async_cmd", {bus.mem_read, bus.mem_write}, 2'b00);
        chk("rw_async_addr", bus.mem_addr, '0);
        chk("rw_async_rdata", bus.i_rdata, '0);
        bus.i_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 256'hDEAD;
        @(negedge clk);
        bus.mem_resp = 1'b0;
        chk("rw_late_resp", {bus.i_resp, bus.d_resp}, 2'b00);
        chk("rw_late_rdata", bus.d_rdata, '0);
        model_last_d = 1'b1;
        bus.d_read = 1'b1;
        bus.d_addr = 32'h0000_0080;
        serve(1'b1, 1'b0, 32'h0000_0080, '0, 1, 1, 256'hF00D);

        // Randomized traffic against the round-robin model
        for (int r = 0; r < 30; r++) begin
            tv.ir  = $urandom_range(0, 1);
            tv.dr  = $urandom_range(0, 1);
            tv.dw  = $urandom_range(0, 1);
            if (!tv.ir && !tv.dr && !tv.dw) tv.ir = 1'b1;
            tv.ia   = $urandom;
            tv.da   = $urandom;
            tv.dwd  = rnd_line();
            tv.rdy  = $urandom_range(0, 3);
            tv.rsp  = $urandom_range(0, 3);
            tv.rd_i = rnd_line();
            tv.rd_d = rnd_line();
            if (tv.ir && (tv.dr || tv.dw)) tv.exp_first_d = !model_last_d;
            else                           tv.exp_first_d = !tv.ir;
            apply(tv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
